// File: rtl/rtc_pkg.sv
// Shared types and helpers for the MM:SS real-time clock controller.
package rtc_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} rtc_state_t;

  localparam bcd_digit_t MAX_UNITS = 4'd9;
  localparam bcd_digit_t MAX_TENS  = 4'd5;

  // t = {m1, m0, s1, s0}; true when every digit is in its BCD range
  function automatic logic bcd_time_valid(input logic [15:0] t);
    return (t[3:0] <= MAX_UNITS) && (t[7:4] <= MAX_TENS) &&
           (t[11:8] <= MAX_UNITS) && (t[15:12] <= MAX_TENS);
  endfunction

endpackage

// File: rtl/tick_generator.sv
// Once-per-second prescaler. Counts only while enabled and is held at zero
// otherwise, so the first pulse comes TICKS_PER_SEC cycles after enabling.
module tick_generator #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic sec_pulse
);

  localparam int unsigned CntW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CntW-1:0] TermCount = CntW'(TICKS_PER_SEC - 1);

  logic [CntW-1:0] r_count;

  assign sec_pulse = enable && (r_count == TermCount);

  // Prescaler: clear when disabled or on terminal count, else count up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (!enable || sec_pulse) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/rtc_time_controller.sv
// Run/set controller for the MM:SS real-time clock: switch capture with BCD
// validation, IDLE/RUN/PAUSE sequencing and the per-second BCD cascade.
// Optional alarm feature is enabled with the RTC_ALARM_EN macro.
module rtc_time_controller
  import rtc_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] switches,
  input  logic        load,
  input  logic        start_stop,
  output logic [3:0]  digit_second_0,
  output logic [3:0]  digit_second_1,
  output logic [3:0]  digit_minute_0,
  output logic [3:0]  digit_minute_1,
  output logic        running,
  output logic        load_error,
  output logic        rollover
`ifdef RTC_ALARM_EN
  ,
  input  logic        alarm_set,
  input  logic        alarm_clear,
  output logic        alarm
`endif
);

  rtc_state_t r_state;
  bcd_digit_t r_s0, r_s1, r_m0, r_m1;
  logic       r_running;
  logic       r_load_error;
  logic       r_rollover;

  logic        w_enable;
  logic        w_sec_pulse;
  logic        w_sw_valid;
  logic        w_load_acc;
  logic        w_alarm_set;
  logic        w_wrap;
  logic [15:0] w_cur_time;
  logic [15:0] w_inc_time;

  assign w_enable   = (r_state == RUN);
  assign w_sw_valid = bcd_time_valid(switches);
  assign w_load_acc = load && (r_state != RUN);
  assign w_cur_time = {r_m1, r_m0, r_s1, r_s0};

`ifdef RTC_ALARM_EN
  assign w_alarm_set = alarm_set;
`else
  assign w_alarm_set = 1'b0;
`endif

  tick_generator #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_generator (
    .clk      (clk),
    .reset    (reset),
    .enable   (w_enable),
    .sec_pulse(w_sec_pulse)
  );

  // BCD cascade: next time one second on; w_wrap flags 59:59 -> 00:00.
  // Out-of-range digits are treated as terminal so the result stays BCD.
  always_comb begin
    w_inc_time = w_cur_time;
    w_wrap     = 1'b0;
    if (r_s0 < MAX_UNITS) begin
      w_inc_time[3:0] = r_s0 + 4'd1;
    end else begin
      w_inc_time[3:0] = 4'd0;
      if (r_s1 < MAX_TENS) begin
        w_inc_time[7:4] = r_s1 + 4'd1;
      end else begin
        w_inc_time[7:4] = 4'd0;
        if (r_m0 < MAX_UNITS) begin
          w_inc_time[11:8] = r_m0 + 4'd1;
        end else begin
          w_inc_time[11:8] = 4'd0;
          if (r_m1 < MAX_TENS) begin
            w_inc_time[15:12] = r_m1 + 4'd1;
          end else begin
            w_inc_time[15:12] = 4'd0;
            w_wrap            = 1'b1;
          end
        end
      end
    end
  end

  // FSM with registered outputs: time digits, error flag, rollover, running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_running    <= 1'b0;
      r_s0         <= '0;
      r_s1         <= '0;
      r_m0         <= '0;
      r_m1         <= '0;
      r_load_error <= 1'b0;
      r_rollover   <= 1'b0;
    end else begin
      r_rollover <= 1'b0;

      // sec_pulse only occurs in RUN and loads only outside RUN: exclusive
      if (w_sec_pulse) begin
        {r_m1, r_m0, r_s1, r_s0} <= w_inc_time;
        r_rollover               <= w_wrap;
      end else if (w_load_acc && w_sw_valid) begin
        {r_m1, r_m0, r_s1, r_s0} <= switches;
      end

      // Sticky until the next capture attempt (time or alarm) that is valid
      if (w_load_acc || w_alarm_set) begin
        r_load_error <= !w_sw_valid;
      end

      case (r_state)
        IDLE, PAUSE: begin
          // A simultaneous load takes priority and swallows start_stop
          if (!load && start_stop) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (start_stop) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

`ifdef RTC_ALARM_EN
  logic [15:0] r_alarm_time;
  logic        r_alarm_armed;
  logic        r_alarm;

  // Alarm register capture and sticky alarm flag raised on a RUN-time match
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alarm_time  <= '0;
      r_alarm_armed <= 1'b0;
      r_alarm       <= 1'b0;
    end else begin
      if (alarm_set && w_sw_valid) begin
        r_alarm_time  <= switches;
        r_alarm_armed <= 1'b1;
      end
      if (w_sec_pulse && r_alarm_armed && (w_inc_time == r_alarm_time)) begin
        r_alarm <= 1'b1;
      end else if (alarm_clear) begin
        r_alarm <= 1'b0;
      end
    end
  end

  assign alarm = r_alarm;
`endif

  assign digit_second_0 = r_s0;
  assign digit_second_1 = r_s1;
  assign digit_minute_0 = r_m0;
  assign digit_minute_1 = r_m1;
  assign running        = r_running;
  assign load_error     = r_load_error;
  assign rollover       = r_rollover;

endmodule

// File: tb/tb_rtc_time_controller.sv
// Self-checking bench for rtc_time_controller (TICKS_PER_SEC = 4).
// Define RTC_ALARM_EN to also exercise the alarm feature.
module tb_rtc_time_controller;

  localparam int TPS = 4;

  logic        clk;
  logic        reset;
  logic [15:0] switches;
  logic        load;
  logic        start_stop;
  logic [3:0]  ds0, ds1, dm0, dm1;
  logic        running, load_error, rollover;
`ifdef RTC_ALARM_EN
  logic        alarm_set, alarm_clear, alarm;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rtc_time_controller #(
    .TICKS_PER_SEC(TPS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .switches      (switches),
    .load          (load),
    .start_stop    (start_stop),
    .digit_second_0(ds0),
    .digit_second_1(ds1),
    .digit_minute_0(dm0),
    .digit_minute_1(dm1),
    .running       (running),
    .load_error    (load_error),
    .rollover      (rollover)
`ifdef RTC_ALARM_EN
    ,
    .alarm_set     (alarm_set),
    .alarm_clear   (alarm_clear),
    .alarm         (alarm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] dut_time;
  assign dut_time = {dm1, dm0, ds1, ds0};

  // Reference model: time as a count of seconds, mode 0=idle 1=run 2=pause,
  // m_age = cycles spent in the current run stretch.
  int m_secs, m_mode, m_age;
  bit m_err, m_roll;

  function automatic bit sw_valid(input logic [15:0] sw);
    return (sw[3:0] < 10) && (sw[7:4] < 6) && (sw[11:8] < 10) && (sw[15:12] < 6);
  endfunction

  function automatic int sw_secs(input logic [15:0] sw);
    return int'(sw[3:0]) + 10 * int'(sw[7:4]) + 60 * (int'(sw[11:8]) + 10 * int'(sw[15:12]));
  endfunction

  function automatic logic [15:0] secs_to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic void model_reset();
    m_secs = 0;
    m_mode = 0;
    m_age  = 0;
    m_err  = 0;
    m_roll = 0;
  endfunction

  function automatic void model_step(input bit ld, input bit ss, input logic [15:0] sw);
    bit tick;
    tick   = (m_mode == 1) && (m_age % TPS == TPS - 1);
    m_roll = 0;
    if (tick) begin
      if (m_secs == 3599) begin
        m_secs = 0;
        m_roll = 1;
      end else begin
        m_secs = m_secs + 1;
      end
    end else if (ld && m_mode != 1) begin
      if (sw_valid(sw)) begin
        m_secs = sw_secs(sw);
        m_err  = 0;
      end else begin
        m_err = 1;
      end
    end
    if (m_mode == 1) begin
      m_age = m_age + 1;
      if (ss) m_mode = 2;
    end else if (!ld && ss) begin
      m_mode = 1;
      m_age  = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " time"}, dut_time, secs_to_bcd(m_secs));
    chk({tag, " running"}, {15'd0, running}, {15'd0, m_mode == 1});
    chk({tag, " load_error"}, {15'd0, load_error}, {15'd0, m_err});
    chk({tag, " rollover"}, {15'd0, rollover}, {15'd0, m_roll});
  endtask

  // Called at a falling edge; drives one cycle of inputs and returns at the next falling edge
  task automatic step(input bit ld, input bit ss, input logic [15:0] sw);
    load       = ld;
    start_stop = ss;
    switches   = sw;
    @(posedge clk);
    model_step(ld, ss, sw);
    @(negedge clk);
    load       = 1'b0;
    start_stop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        ld;
    logic        ss;
    logic [15:0] sw;
    logic [15:0] t;
    logic        run;
    logic        err;
    logic        roll;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic [15:0] frozen;
    logic [15:0] rsw;

    // ld, ss, switches, expected time, running, load_error, rollover
    vecs[0]  = '{1'b1, 1'b0, 16'h1A00, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h1200, 16'h1200, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h6000, 16'h1200, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0959, 16'h0959, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 16'h5958, 16'h5958, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'h0000, 16'h5958, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h5958, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h5958, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 16'h5958, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'h5959, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 16'h3000, 16'h5959, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 16'h5959, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 16'h0000, 16'h5959, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 16'h3000, 16'h3000, 1'b0, 1'b0, 1'b0};

    reset      = 1'b1;
    load       = 1'b0;
    start_stop = 1'b0;
    switches   = 16'h0000;
`ifdef RTC_ALARM_EN
    alarm_set   = 1'b0;
    alarm_clear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset time", dut_time, 16'h0000);
    chk("reset running", {15'd0, running}, 16'd0);
    chk("reset load_error", {15'd0, load_error}, 16'd0);
    chk("reset rollover", {15'd0, rollover}, 16'd0);
    reset = 1'b0;
    model_reset();

    // Directed vector table
    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].ss, vecs[i].sw);
      chk($sformatf("vec%0d time", i), dut_time, vecs[i].t);
      chk($sformatf("vec%0d running", i), {15'd0, running}, {15'd0, vecs[i].run});
      chk($sformatf("vec%0d load_error", i), {15'd0, load_error}, {15'd0, vecs[i].err});
      chk($sformatf("vec%0d rollover", i), {15'd0, rollover}, {15'd0, vecs[i].roll});
    end

    // start_stop on the sec_pulse cycle: increment happens and state pauses
    do_reset();
    step(1'b0, 1'b1, 16'h0000);
    repeat (3) step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h0000);
    chk("ss on tick time", dut_time, 16'h0001);
    chk("ss on tick running", {15'd0, running}, 16'd0);
    check_model("ss on tick");

    // Paused digits stay frozen
    frozen = dut_time;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 16'h0000);
      chk("pause frozen", dut_time, frozen);
    end
    step(1'b1, 1'b0, 16'h0130);
    chk("pause load", dut_time, 16'h0130);
    step(1'b0, 1'b1, 16'h0000);
    repeat (TPS) step(1'b0, 1'b0, 16'h0000);
    chk("resume count", dut_time, 16'h0131);
    check_model("resume");

    // Asynchronous reset while counting from 07:33
    do_reset();
    step(1'b1, 1'b0, 16'h0733);
    step(1'b0, 1'b1, 16'h0000);
    repeat (6) step(1'b0, 1'b0, 16'h0000);
    check_model("pre-reset");
    #2 reset = 1'b1;
    #1;
    chk("async reset time", dut_time, 16'h0000);
    chk("async reset running", {15'd0, running}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2 * TPS) step(1'b0, 1'b0, 16'h0000);
    check_model("idle after reset");

    // Randomised traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       rsw = 16'($urandom);
        1:       rsw = secs_to_bcd($urandom_range(3590, 3599));
        default: rsw = secs_to_bcd($urandom_range(0, 3599));
      endcase
      step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, rsw);
      check_model("rand");
    end

`ifdef RTC_ALARM_EN
    // Alarm at 00:02, then cleared
    do_reset();
    switches  = 16'h0002;
    alarm_set = 1'b1;
    @(negedge clk);
    alarm_set = 1'b0;
    step(1'b0, 1'b1, 16'h0000);
    repeat (2 * TPS - 1) step(1'b0, 1'b0, 16'h0000);
    chk("alarm before match", {15'd0, alarm}, 16'd0);
    step(1'b0, 1'b0, 16'h0000);
    chk("alarm match time", dut_time, 16'h0002);
    chk("alarm raised", {15'd0, alarm}, 16'd1);
    alarm_clear = 1'b1;
    @(negedge clk);
    alarm_clear = 1'b0;
    chk("alarm cleared", {15'd0, alarm}, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
